fwrisc_trap_ctrl: RTL and testbench

FWRISC_TRAP_CTRL -- requirements
Module: fwrisc_trap_ctrl

---
 rtl/fwrisc_trap_ctrl.sv | 127 ++++++++++++
 tb/tb_fwrisc_trap_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_trap_ctrl.sv
// Trap and MRET sequencer for fwrisc. Takes over the regfile write port to save
// MEPC and MCAUSE, then redirects fetch to the trap vector or back to MEPC.
module fwrisc_trap_ctrl #(
    parameter logic [5:0] MEPC_ADDR   = 6'h2A,
    parameter logic [5:0] MCAUSE_ADDR = 6'h2B,
    parameter logic [3:0] IRQ_CAUSE   = 4'd11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] cur_pc,
    input  logic        instr_boundary,
    input  logic        irq,
    input  logic        meie,
    input  logic        mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mret_req,
    output logic        busy,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        trap,
    output logic        tret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {IDLE, WR_EPC, WR_CAUSE, REDIRECT, RET} state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic        int_q, int_d;
    logic        idle, take_irq, accept_exc, accept_irq, accept_ret;
    logic [31:0] vec_base;

    // Nothing is accepted while reset is held, so the cycle after reset stays quiet.
    always_comb begin
        idle       = (state_q == IDLE) && !reset;
        take_irq   = irq && meie && mie && instr_boundary && !exc_req;
        accept_exc = idle && exc_req;
        accept_irq = idle && take_irq;
        accept_ret = idle && mret_req && !exc_req && !take_irq;
    end

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        int_d   = int_q;
        case (state_q)
            IDLE: begin
                if (accept_exc || accept_irq) begin
                    state_d = WR_EPC;
                    epc_d   = cur_pc;
                    cause_d = accept_exc ? exc_cause : IRQ_CAUSE;
                    int_d   = accept_irq;
                end else if (accept_ret) begin
                    state_d = RET;
                end
            end
            WR_EPC:        state_d = WR_CAUSE;
            WR_CAUSE:      state_d = REDIRECT;
            REDIRECT, RET: state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            epc_q   <= 32'h0;
            cause_q <= 4'h0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            int_q   <= int_d;
        end
    end

    // mtvec is read live in REDIRECT so a CSR write landing mid-sequence is honoured.
    always_comb begin
        vec_base       = {mtvec[31:2], 2'b00};
        busy           = !reset && ((state_q != IDLE) || accept_exc || accept_irq || accept_ret);
        wr_en          = 1'b0;
        wr_addr        = 6'h0;
        wr_data        = 32'h0;
        trap           = 1'b0;
        tret           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (!reset) begin
            case (state_q)
                WR_EPC: begin
                    wr_en   = 1'b1;
                    wr_addr = MEPC_ADDR;
                    wr_data = epc_q;
                    trap    = 1'b1;
                end
                WR_CAUSE: begin
                    wr_en   = 1'b1;
                    wr_addr = MCAUSE_ADDR;
                    wr_data = {int_q, 27'b0, cause_q};
                end
                REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = (mtvec[1:0] == 2'b01 && int_q)
                                   ? vec_base + {26'b0, cause_q, 2'b00}
                                   : vec_base;
                end
                RET: begin
                    tret           = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = {mepc[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_trap_ctrl.sv
// Bench for fwrisc_trap_ctrl: directed scenarios plus a randomized run against a
// reference model that replays each accepted request as a script of expected cycles.
module tb_fwrisc_trap_ctrl;

    logic        clock, reset;
    logic        exc_req, irq, meie, mie, instr_boundary, mret_req;
    logic [3:0]  exc_cause;
    logic [31:0] cur_pc, mtvec, mepc;
    logic        busy, wr_en, trap, tret, redirect_valid;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data, redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        busy;
        logic        wr_en;
        logic [5:0]  wr_addr;
        logic [31:0] wr_data;
        logic        trap;
        logic        tret;
        logic        rv;
        logic [31:0] rpc;
    } out_t;

    typedef enum {K_EPC, K_CAUSE, K_REDIR, K_RET} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] epc;
        logic [3:0]  cause;
        logic        intr;
    } step_t;

    out_t got, exp;

    fwrisc_trap_ctrl dut (
        .clock(clock), .reset(reset), .exc_req(exc_req), .exc_cause(exc_cause),
        .cur_pc(cur_pc), .instr_boundary(instr_boundary), .irq(irq), .meie(meie),
        .mie(mie), .mtvec(mtvec), .mepc(mepc), .mret_req(mret_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trap(trap), .tret(tret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic out_t sample();
        out_t s;
        s.busy = busy; s.wr_en = wr_en; s.wr_addr = wr_addr; s.wr_data = wr_data;
        s.trap = trap; s.tret = tret; s.rv = redirect_valid; s.rpc = redirect_pc;
        return s;
    endfunction

    function automatic out_t o(input logic b, input logic w, input logic [5:0] a,
                               input logic [31:0] d, input logic t, input logic r,
                               input logic v, input logic [31:0] p);
        out_t s;
        s.busy = b; s.wr_en = w; s.wr_addr = a; s.wr_data = d;
        s.trap = t; s.tret = r; s.rv = v; s.rpc = p;
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        exc_req = 0; exc_cause = 0; cur_pc = 0; instr_boundary = 0; irq = 0;
        meie = 0; mie = 0; mtvec = 0; mepc = 0; mret_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        exc_req = 1; mret_req = 1; cur_pc = 32'h44;
        tick(); tick();
        @(negedge clock); got = sample(); exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL reset_outputs got %h exp %h", got, exp); end
        checks++;
        tick();
        reset = 0; clear_inputs();
        @(negedge clock); got = sample();
        if (got !== exp) begin errors++; $display("FAIL reset_release got %h exp %h", got, exp); end
        checks++;
        tick();
    endtask

    task automatic test_exception();
        exc_req = 1; exc_cause = 4'd2; cur_pc = 32'h100; mtvec = 32'h200;
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL exc_accept got %h exp %h", got, exp); end
        checks++;
        tick(); exc_req = 0; exc_cause = 4'd9; cur_pc = 32'hDEAD_BEE0;
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2A, 32'h100, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL exc_epc got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2B, 32'h2, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL exc_cause got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h200);
        if (got !== exp) begin errors++; $display("FAIL exc_redirect got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL exc_done got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    task automatic test_interrupt();
        irq = 1; meie = 1; mie = 1; instr_boundary = 1; mtvec = 32'h201; cur_pc = 32'h40;
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL irq_accept got %h exp %h", got, exp); end
        checks++;
        tick(); irq = 0;
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2A, 32'h40, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL irq_epc got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2B, 32'h8000_000B, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL irq_cause got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h22C);
        if (got !== exp) begin errors++; $display("FAIL irq_redirect got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    // Vector base changes after accept and the vectored sum wraps past 2^32.
    task automatic test_vector_wrap();
        irq = 1; meie = 1; mie = 1; instr_boundary = 1; mtvec = 32'h0; cur_pc = 32'h8;
        tick(); irq = 0; mtvec = 32'hFFFF_FFFD;
        tick(); tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h28);
        if (got !== exp) begin errors++; $display("FAIL vec_wrap got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    task automatic test_masking();
        irq = 1; meie = 1; mie = 0; instr_boundary = 1; mtvec = 32'h201; cur_pc = 32'h40;
        exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin mie = 1; instr_boundary = 0; end
            if (i == 2) begin instr_boundary = 1; meie = 0; end
            @(negedge clock); got = sample();
            if (got !== exp) begin errors++; $display("FAIL mask_%0d got %h exp %h", i, got, exp); end
            checks++;
            tick();
            @(negedge clock); got = sample();
            if (got !== exp) begin errors++; $display("FAIL mask_after_%0d got %h exp %h", i, got, exp); end
            checks++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        exc_req = 1; exc_cause = 4'd3; irq = 1; meie = 1; mie = 1; instr_boundary = 1;
        mret_req = 1; mepc = 32'h999; cur_pc = 32'h80; mtvec = 32'h201;
        tick(); clear_inputs(); mtvec = 32'h201;
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2A, 32'h80, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL prio_epc got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2B, 32'h3, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL prio_cause got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h200);
        if (got !== exp) begin errors++; $display("FAIL prio_redirect got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL prio_no_mret got %h exp %h", got, exp); end
        checks++;
        tick();
    endtask

    task automatic test_mret();
        mret_req = 1; mepc = 32'h1237;
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL mret_accept got %h exp %h", got, exp); end
        checks++;
        tick(); mret_req = 0;
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 1, 1, 32'h1234);
        if (got !== exp) begin errors++; $display("FAIL mret_ret got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL mret_done got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    task automatic test_reset_abort();
        exc_req = 1; exc_cause = 4'd5; cur_pc = 32'h300; mtvec = 32'h400;
        tick(); exc_req = 0;
        tick(); reset = 1;
        @(negedge clock); got = sample(); exp = o(0, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL abort_cause got %h exp %h", got, exp); end
        checks++;
        tick(); reset = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); got = sample();
            if (got !== exp) begin errors++; $display("FAIL abort_idle_%0d got %h exp %h", i, got, exp); end
            checks++;
            tick();
        end
        exc_req = 1; exc_cause = 4'd7; cur_pc = 32'h500;
        tick(); exc_req = 0;
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2A, 32'h500, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL abort_re_epc got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2B, 32'h7, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL abort_re_cause got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h400);
        if (got !== exp) begin errors++; $display("FAIL abort_re_redirect got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    // Held exception is re-accepted on the return cycle; a held mret waits out a trap.
    task automatic test_back_to_back();
        exc_req = 1; exc_cause = 4'd1; cur_pc = 32'h10; mtvec = 32'h100;
        tick(); tick(); tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h100);
        if (got !== exp) begin errors++; $display("FAIL b2b_redirect got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL b2b_reaccept got %h exp %h", got, exp); end
        checks++;
        tick(); exc_req = 0; mret_req = 1; mepc = 32'h2222;
        @(negedge clock); got = sample(); exp = o(1, 1, 6'h2A, 32'h10, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL b2b_epc got %h exp %h", got, exp); end
        checks++;
        tick(); tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 1, 32'h100);
        if (got !== exp) begin errors++; $display("FAIL b2b_redirect2 got %h exp %h", got, exp); end
        checks++;
        tick();
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL b2b_mret_accept got %h exp %h", got, exp); end
        checks++;
        tick(); mret_req = 0;
        @(negedge clock); got = sample(); exp = o(1, 0, 0, 0, 0, 1, 1, 32'h2220);
        if (got !== exp) begin errors++; $display("FAIL b2b_ret got %h exp %h", got, exp); end
        checks++;
        tick(); clear_inputs();
    endtask

    // Each accepted request expands into its script of per-cycle register writes/redirects.
    task automatic test_random();
        step_t       pend[$];
        step_t       s;
        logic [31:0] base;
        logic        take_irq;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset          = (cyc == 0) || ($urandom_range(0, 49) == 0);
            exc_req        = ($urandom_range(0, 3) == 0);
            exc_cause      = 4'($urandom);
            cur_pc         = $urandom;
            irq            = 1'($urandom_range(0, 1));
            meie           = ($urandom_range(0, 3) != 0);
            mie            = ($urandom_range(0, 3) != 0);
            instr_boundary = 1'($urandom_range(0, 1));
            mret_req       = ($urandom_range(0, 3) == 0);
            mtvec          = $urandom;
            mepc           = $urandom;
            take_irq       = irq && meie && mie && instr_boundary && !exc_req;
            exp = o(0, 0, 0, 0, 0, 0, 0, 0);
            if (!reset) begin
                if (pend.size() > 0) begin
                    s = pend[0];
                    exp.busy = 1;
                    base = mtvec & 32'hFFFF_FFFC;
                    case (s.kind)
                        K_EPC: begin
                            exp.wr_en = 1; exp.wr_addr = 6'h2A; exp.wr_data = s.epc; exp.trap = 1;
                        end
                        K_CAUSE: begin
                            exp.wr_en = 1; exp.wr_addr = 6'h2B;
                            exp.wr_data = (s.intr ? 32'h8000_0000 : 32'h0) + 32'(s.cause);
                        end
                        K_REDIR: begin
                            exp.rv = 1;
                            exp.rpc = (mtvec[1:0] == 2'b01 && s.intr) ? base + 32'(s.cause) * 4 : base;
                        end
                        default: begin
                            exp.tret = 1; exp.rv = 1; exp.rpc = mepc & 32'hFFFF_FFFC;
                        end
                    endcase
                end else begin
                    exp.busy = exc_req || take_irq || mret_req;
                end
            end
            @(negedge clock); got = sample();
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_cycle_%0d got %h exp %h", cyc, got, exp);
            end
            checks++;
            if (reset) begin
                pend.delete();
            end else if (pend.size() > 0) begin
                void'(pend.pop_front());
            end else if (exc_req || take_irq) begin
                s.epc   = cur_pc;
                s.cause = exc_req ? exc_cause : 4'd11;
                s.intr  = !exc_req;
                s.kind = K_EPC;   pend.push_back(s);
                s.kind = K_CAUSE; pend.push_back(s);
                s.kind = K_REDIR; pend.push_back(s);
            end else if (mret_req) begin
                s.kind = K_RET; pend.push_back(s);
            end
            tick();
        end
        reset = 1; clear_inputs();
        tick();
        reset = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt();
        test_vector_wrap();
        test_masking();
        test_priority();
        test_mret();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
